// File: rtl/hex_scan_driver_if.sv
// Bundles the value/strobe inputs and the segment/grid/frame outputs of the hex scan driver.
// The master drives Value/Load/Dp/Suppress; the slave (the driver) owns the display pins.
interface hex_scan_driver_if;
  logic [15:0] Value;
  logic        Load;
  logic [3:0]  Dp;
  logic        Suppress;
  logic [7:0]  hex_seg;
  logic [3:0]  hex_grid;
  logic        Frame;

  modport master (
    output Value, Load, Dp, Suppress,
    input  hex_seg, hex_grid, Frame
  );

  modport slave (
    input  Value, Load, Dp, Suppress,
    output hex_seg, hex_grid, Frame
  );
endinterface

// File: rtl/hex_scan_driver.sv
// Four-digit multiplexed active-low seven-segment scanner. The shadow word is committed to
// the display only at frame boundaries, and every slot opens with a short blanking guard.
module hex_scan_driver #(
  parameter int DIV_CYCLES   = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  hex_scan_driver_if.slave bus
);

  localparam int            CW      = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] GUARD   = CW'(GUARD_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_sh;
  logic          r_pend;
  logic [15:0]   r_disp;
  logic [7:0]    r_seg;
  logic [3:0]    r_grid;
  logic          r_frame;

  logic          w_wrap;
  logic          w_commit;
  logic [3:0]    w_nib;
  logic          w_lead;
  logic [6:0]    w_segs;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_wrap   = (r_cnt == CNT_MAX);
  assign w_commit = w_wrap && (r_idx == 2'd3);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap)
        r_idx <= r_idx + 2'd1;
    end
  end

  // On a Load/commit collision the display takes the old shadow word, and the new one
  // stays pending for the following frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sh    <= 16'h0000;
      r_pend  <= 1'b0;
      r_disp  <= 16'h0000;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_commit;
      if (w_commit && r_pend)
        r_disp <= r_sh;
      if (bus.Load) begin
        r_sh   <= bus.Value;
        r_pend <= 1'b1;
      end else if (w_commit) begin
        r_pend <= 1'b0;
      end
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    w_nib  = 4'h0;
    w_lead = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib  = r_disp[3:0];
        w_lead = 1'b0;
      end
      2'd1: begin
        w_nib  = r_disp[7:4];
        w_lead = (r_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib  = r_disp[11:8];
        w_lead = (r_disp[15:8] == 8'h00);
      end
      default: begin
        w_nib  = r_disp[15:12];
        w_lead = (r_disp[15:12] == 4'h0);
      end
    endcase
    w_segs = (bus.Suppress && w_lead) ? 7'h00 : seg7(w_nib);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_seg  <= 8'hFF;
      r_grid <= 4'hF;
    end else if (r_cnt < GUARD) begin
      r_seg  <= 8'hFF;
      r_grid <= 4'hF;
    end else begin
      r_seg  <= ~{bus.Dp[r_idx], w_segs};
      r_grid <= ~(4'b0001 << r_idx);
    end
  end

  assign bus.hex_seg  = r_seg;
  assign bus.hex_grid = r_grid;
  assign bus.Frame    = r_frame;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed and randomized bench for hex_scan_driver with DIV_CYCLES=8, GUARD_CYCLES=2,
// checked every cycle against a frame-arithmetic reference model.
module tb_hex_scan_driver;
  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  hex_scan_driver_if bus();

  hex_scan_driver #(
    .DIV_CYCLES  (DIV),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nFails  = 0;

  logic [6:0] segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: edges since reset release, shadow word, pending flag, displayed word.
  int          e;
  logic [15:0] mSh;
  logic [15:0] mDisp;
  bit          mPend;
  logic [7:0]  expSeg;
  logic [3:0]  expGrid;
  logic        expFrame;

  task automatic modelReset();
    e        = 0;
    mSh      = 16'h0000;
    mDisp    = 16'h0000;
    mPend    = 1'b0;
    expSeg   = 8'hFF;
    expGrid  = 4'hF;
    expFrame = 1'b0;
  endtask

  // Slot position and digit follow directly from the number of edges since reset.
  task automatic modelEdge();
    int         c;
    int         d;
    logic [3:0] nib;
    logic [6:0] s;
    logic [3:0] one;
    bit         commit;
    if (!Reset_n) begin
      modelReset();
      return;
    end
    c   = e % DIV;
    d   = (e / DIV) % 4;
    one = 4'b0001;
    if (c < GUARD) begin
      expGrid = 4'hF;
      expSeg  = 8'hFF;
    end else begin
      nib = 4'(mDisp >> (4 * d));
      s   = segTab[nib];
      if (bus.Suppress && d != 0 && (mDisp >> (4 * d)) == 16'h0000)
        s = 7'h00;
      expGrid = ~(one << d);
      expSeg  = ~{bus.Dp[d], s};
    end
    commit   = (c == DIV - 1) && (d == 3);
    expFrame = commit;
    if (commit && mPend)
      mDisp = mSh;
    if (bus.Load) begin
      mSh   = bus.Value;
      mPend = 1'b1;
    end else if (commit) begin
      mPend = 1'b0;
    end
    e++;
  endtask

  task automatic applyStimulus(input logic [15:0] value, input logic load,
                               input logic [3:0] dp, input logic supp);
    bus.Value    = value;
    bus.Load     = load;
    bus.Dp       = dp;
    bus.Suppress = supp;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] seg,
                             input logic [3:0] grid, input logic frame);
    nChecks++;
    assert (bus.hex_seg === seg) else begin
      nFails++;
      $error("FAIL %s hex_seg observed=%h expected=%h", tag, bus.hex_seg, seg);
    end
    nChecks++;
    assert (bus.hex_grid === grid) else begin
      nFails++;
      $error("FAIL %s hex_grid observed=%h expected=%h", tag, bus.hex_grid, grid);
    end
    nChecks++;
    assert (bus.Frame === frame) else begin
      nFails++;
      $error("FAIL %s Frame observed=%b expected=%b", tag, bus.Frame, frame);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    modelEdge();
    #1;
    checkOutput(tag, expSeg, expGrid, expFrame);
  endtask

  task automatic waitFrame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(tag);
      if (bus.Frame === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    nChecks++;
    assert (seen) else begin
      nFails++;
      $error("FAIL %s frame_timeout observed=0 expected=1 within 40 cycles", tag);
    end
  endtask

  // Walks one full frame starting right after a Frame pulse, checking each digit's drive.
  task automatic checkFrameDigits(input string tag, input logic [31:0] segs,
                                  input logic [15:0] grids);
    for (int d = 0; d < 4; d++) begin
      tick(tag);
      tick(tag);
      tick(tag);
      checkOutput(tag, segs[8*d +: 8], grids[4*d +: 4], 1'b0);
      repeat (5) tick(tag);
    end
  endtask

  initial begin
    applyStimulus($urandom, 1'b1, 4'h0, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset_hold", 8'hFF, 4'hF, 1'b0);

    applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
    Reset_n = 1'b1;
    modelReset();
    tick("release_guard");
    checkOutput("release_guard0", 8'hFF, 4'hF, 1'b0);
    tick("release_guard");
    checkOutput("release_guard1", 8'hFF, 4'hF, 1'b0);
    repeat (6) begin
      tick("release_digit0");
      checkOutput("release_digit0", 8'hC0, 4'hE, 1'b0);
    end
    waitFrame("first_frame");

    applyStimulus(16'hFE63, 1'b1, 4'h0, 1'b0);
    tick("load_fe63");
    applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
    waitFrame("commit_fe63");
    checkFrameDigits("scan_fe63", {8'h8E, 8'h86, 8'h82, 8'hB0}, {4'h7, 4'hB, 4'hD, 4'hE});

    repeat (10) tick("pre_tear");
    applyStimulus(16'h019D, 1'b1, 4'h0, 1'b0);
    tick("load_019d");
    applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
    tick("tear_free");
    checkOutput("tear_free", 8'h82, 4'hD, 1'b0);
    waitFrame("commit_019d");
    checkFrameDigits("scan_019d", {8'hC0, 8'hF9, 8'h90, 8'hA1}, {4'h7, 4'hB, 4'hD, 4'hE});

    repeat (4) tick("collide_pre");
    applyStimulus(16'h2222, 1'b1, 4'h0, 1'b0);
    tick("load_2222");
    applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
    repeat (26) tick("collide_wait");
    applyStimulus(16'h5B3C, 1'b1, 4'h0, 1'b0);
    tick("load_on_commit");
    checkOutput("load_on_commit", expSeg, expGrid, 1'b1);
    applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
    checkFrameDigits("scan_2222", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, {4'h7, 4'hB, 4'hD, 4'hE});
    checkFrameDigits("scan_5b3c", {8'h92, 8'h83, 8'hB0, 8'hC6}, {4'h7, 4'hB, 4'hD, 4'hE});

    applyStimulus(16'h0007, 1'b1, 4'h0, 1'b0);
    tick("load_0007");
    applyStimulus(16'h0000, 1'b0, 4'b0100, 1'b1);
    waitFrame("commit_0007");
    checkFrameDigits("suppress", {8'hFF, 8'h7F, 8'hFF, 8'hF8}, {4'h7, 4'hB, 4'hD, 4'hE});

    repeat (300) begin
      applyStimulus($urandom, ($urandom % 6) == 0, 4'($urandom), 1'($urandom));
      tick("random");
    end
    applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);

    waitFrame("pre_reset");
    repeat (19) tick("digit2_drive");
    Reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset_async", 8'hFF, 4'hF, 1'b0);
    applyStimulus($urandom, 1'b1, 4'h0, 1'b0);
    tick("in_reset");
    applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
    Reset_n = 1'b1;
    tick("restart_guard");
    tick("restart_guard");
    tick("restart_digit0");
    checkOutput("restart_digit0", 8'hC0, 4'hE, 1'b0);
    waitFrame("restart_frame");
    checkFrameDigits("restart_zero", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
